// File: rtl/serial_paralelo.sv
// Receive-side deserializer: aligns an MSB-first bit stream to byte boundaries
// using a comma symbol, then emits one byte with a valid flag every 8 clocks once locked.
module serial_paralelo #(
   parameter logic [7:0] COMMA   = 8'hBC,
   parameter int         N_COMMA = 4
) (
   input  logic       clk_32f,
   input  logic       reset_L,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       active,
   output logic       byte_strobe
);

   typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

   localparam logic [3:0] N_COMMA_L = 4'(N_COMMA);

   state_t     state_reg;
   logic [6:0] sr_reg;
   logic [2:0] bit_cnt_reg;
   logic [3:0] comma_cnt_reg;
   logic [7:0] data_out_reg;
   logic       valid_out_reg;
   logic       active_reg;
   logic       byte_strobe_reg;

   // Candidate byte includes the bit arriving on this edge, so a byte is usable
   // on the same edge its LSB is sampled.
   logic [7:0] nb;
   logic       is_comma;
   logic       at_boundary;
   logic [3:0] comma_inc;

   assign nb          = {sr_reg, data_in};
   assign is_comma    = (nb == COMMA);
   assign at_boundary = (bit_cnt_reg == 3'd7);
   assign comma_inc   = comma_cnt_reg + 4'd1;

   always_ff @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) begin
         state_reg       <= SEARCH;
         sr_reg          <= '0;
         bit_cnt_reg     <= '0;
         comma_cnt_reg   <= '0;
         data_out_reg    <= '0;
         valid_out_reg   <= 1'b0;
         active_reg      <= 1'b0;
         byte_strobe_reg <= 1'b0;
      end else begin
         sr_reg          <= nb[6:0];
         byte_strobe_reg <= 1'b0;
         case (state_reg)
            SEARCH: begin
               if (is_comma) begin
                  bit_cnt_reg   <= '0;
                  comma_cnt_reg <= 4'd1;
                  if (N_COMMA_L == 4'd1) begin
                     state_reg  <= LOCKED;
                     active_reg <= 1'b1;
                  end else begin
                     state_reg <= ALIGN;
                  end
               end
            end
            ALIGN: begin
               bit_cnt_reg <= bit_cnt_reg + 3'd1;
               // A miss sends us back to bit-by-bit hunting from the next edge.
               if (at_boundary) begin
                  if (is_comma) begin
                     comma_cnt_reg <= comma_inc;
                     if (comma_inc == N_COMMA_L) begin
                        state_reg  <= LOCKED;
                        active_reg <= 1'b1;
                     end
                  end else begin
                     comma_cnt_reg <= '0;
                     state_reg     <= SEARCH;
                  end
               end
            end
            LOCKED: begin
               bit_cnt_reg <= bit_cnt_reg + 3'd1;
               if (at_boundary) begin
                  data_out_reg    <= nb;
                  valid_out_reg   <= !is_comma;
                  byte_strobe_reg <= 1'b1;
               end
            end
            default: state_reg <= SEARCH;
         endcase
      end
   end

   assign data_out    = data_out_reg;
   assign valid_out   = valid_out_reg;
   assign active      = active_reg;
   assign byte_strobe = byte_strobe_reg;

endmodule
